// File: rtl/clk_div_pkg.sv
// Shared constants, types and the half-period helper for the multi-channel clock divider.
package clk_div_pkg;

   localparam int DIV_W_DEFAULT    = 24;
   localparam int CLK_FREQ_DEFAULT = 40_000_000;

   typedef logic [DIV_W_DEFAULT-1:0] div_t;

   // A half-period of 0 would leave the counter with no terminal count, so clamp to 1.
   function automatic int half_period(input int clk_freq, input int freq);
      int h;
      h = clk_freq / freq / 2;
      return (h == 0) ? 1 : h;
   endfunction

endpackage

// File: rtl/clk_div_multi_ch.sv
// One divider channel: half-period counter, live and shadow half-period, pending flag,
// registered divided clock and the rising-edge tick.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int               DIV_W    = DIV_W_DEFAULT,
   parameter logic [DIV_W-1:0] HALF_RST = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_wr,
   input  logic [DIV_W-1:0] i_wr_div,
   output logic             o_pending,
   output logic             o_clk_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_half;
   logic [DIV_W-1:0] r_shadow;
   logic             r_pending;
   logic             r_clk_div;
   logic             r_tick;
   logic             w_tc;
   logic             w_apply;

   assign w_tc    = (r_cnt == r_half - DIV_W'(1));
   // Shadow loads only where a half-period boundary is guaranteed: terminal count, hold or sync.
   assign w_apply = i_sync | ~i_en | w_tc;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt     <= '0;
         r_half    <= HALF_RST;
         r_shadow  <= HALF_RST;
         r_pending <= 1'b0;
         r_clk_div <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         if (i_sync || !i_en) begin
            r_cnt     <= '0;
            r_clk_div <= 1'b0;
            r_tick    <= 1'b0;
         end else if (w_tc) begin
            r_cnt     <= '0;
            r_clk_div <= ~r_clk_div;
            r_tick    <= ~r_clk_div;
         end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            r_tick <= 1'b0;
         end
         if (w_apply && r_pending) begin
            r_half    <= r_shadow;
            r_pending <= 1'b0;
         end
         // A write is only accepted while not pending, so it never collides with the apply above.
         if (i_wr) begin
            r_shadow  <= i_wr_div;
            r_pending <= 1'b1;
         end
      end
   end

   assign o_pending = r_pending;
   assign o_clk_div = r_clk_div;
   assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: config decode and ready mux around CHANNELS dividers.
// Optional CLK_DIV_SYNC_EN adds i_sync_start, which re-phases all channels and applies pending writes.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int CLK_FREQ     = CLK_FREQ_DEFAULT,
   parameter int CHANNELS     = 4,
   parameter int DIV_W        = DIV_W_DEFAULT,
   parameter int DEFAULT_FREQ = 400,
   localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [CHANNELS-1:0] i_en,
   input  logic                i_cfg_valid,
   output logic                o_cfg_ready,
   input  logic [CH_W-1:0]     i_cfg_ch,
   input  logic [DIV_W-1:0]    i_cfg_div,
`ifdef CLK_DIV_SYNC_EN
   input  logic                i_sync_start,
`endif
   output logic [CHANNELS-1:0] o_clk_div,
   output logic [CHANNELS-1:0] o_tick
);

   localparam int               RAW_HALF = CLK_FREQ / DEFAULT_FREQ / 2;
   localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(half_period(CLK_FREQ, DEFAULT_FREQ));

   if (RAW_HALF == 0 || (longint'(RAW_HALF) >> DIV_W) != 0) begin : g_bad_half
      $error("clk_div_multi: default half-period %0d is zero or exceeds DIV_W=%0d", RAW_HALF, DIV_W);
   end
   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("clk_div_multi: CHANNELS=%0d outside 1..16", CHANNELS);
   end

   logic [CHANNELS-1:0] w_pending;
   logic [CHANNELS-1:0] w_wr;
   logic [DIV_W-1:0]    w_div;
   logic                w_ready;
   logic                w_sync;

`ifdef CLK_DIV_SYNC_EN
   assign w_sync = i_sync_start;
`else
   assign w_sync = 1'b0;
`endif

   assign w_div = (i_cfg_div == '0) ? DIV_W'(1) : i_cfg_div;

   // Out-of-range channel numbers match no channel: ready stays 1 and the write is dropped.
   always_comb begin
      w_ready = 1'b1;
      w_wr    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (i_cfg_ch == CH_W'(i)) begin
            w_ready = ~w_pending[i];
            w_wr[i] = i_cfg_valid & ~w_pending[i];
         end
      end
   end

   assign o_cfg_ready = w_ready;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      clk_div_ch #(
         .DIV_W    (DIV_W),
         .HALF_RST (HALF_RST)
      ) u_ch (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_en      (i_en[g]),
         .i_sync    (w_sync),
         .i_wr      (w_wr[g]),
         .i_wr_div  (w_div),
         .o_pending (w_pending[g]),
         .o_clk_div (o_clk_div[g]),
         .o_tick    (o_tick[g])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios with literal expectations,
// then randomized traffic against an edge-time model of each channel.
module tb_clk_div_multi;

   localparam int NCH   = 6;
   localparam int CHW   = 3;
   localparam int DIVW  = 24;
   localparam int HALF0 = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [NCH-1:0]  en;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [CHW-1:0]  cfg_ch;
   logic [DIVW-1:0] cfg_div;
   logic [NCH-1:0]  clk_div;
   logic [NCH-1:0]  tick;
`ifdef CLK_DIV_SYNC_EN
   logic            sync_start;
`endif

   clk_div_multi #(
      .CLK_FREQ     (1000),
      .CHANNELS     (NCH),
      .DIV_W        (DIVW),
      .DEFAULT_FREQ (100)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_cfg_valid (cfg_valid),
      .o_cfg_ready (cfg_ready),
      .i_cfg_ch    (cfg_ch),
      .i_cfg_div   (cfg_div),
`ifdef CLK_DIV_SYNC_EN
      .i_sync_start(sync_start),
`endif
      .o_clk_div   (clk_div),
      .o_tick      (tick)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int t      = 0;

   // Model: per channel, the absolute edge index of its next toggle.
   int m_half [NCH];
   int m_shadow [NCH];
   int m_next [NCH];
   bit m_pend [NCH];
   bit m_lvl [NCH];
   bit m_tick [NCH];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, got, exp);
      end
   endtask

   function automatic bit exp_ready(input int ch);
      if (ch >= NCH) return 1'b1;
      return !m_pend[ch];
   endfunction

   function automatic logic [NCH-1:0] vec_lvl();
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) v[i] = m_lvl[i];
      return v;
   endfunction

   function automatic logic [NCH-1:0] vec_tick();
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) v[i] = m_tick[i];
      return v;
   endfunction

   task automatic model_reset();
      t = 0;
      for (int i = 0; i < NCH; i++) begin
         m_half[i]   = HALF0;
         m_shadow[i] = HALF0;
         m_pend[i]   = 1'b0;
         m_lvl[i]    = 1'b0;
         m_tick[i]   = 1'b0;
         m_next[i]   = HALF0;
      end
   endtask

   task automatic model_step(input logic [NCH-1:0] e, input bit hs, input int ch, input int div, input bit s);
      t++;
      for (int i = 0; i < NCH; i++) begin
         bit boundary;
         boundary = 1'b0;
         if (s || !e[i]) begin
            m_lvl[i]  = 1'b0;
            m_tick[i] = 1'b0;
            boundary  = 1'b1;
         end else if (t == m_next[i]) begin
            m_lvl[i]  = !m_lvl[i];
            m_tick[i] = m_lvl[i];
            boundary  = 1'b1;
         end else begin
            m_tick[i] = 1'b0;
         end
         if (boundary) begin
            if (m_pend[i]) begin
               m_half[i] = m_shadow[i];
               m_pend[i] = 1'b0;
            end
            m_next[i] = t + m_half[i];
         end
      end
      if (hs && ch < NCH) begin
         m_shadow[ch] = (div == 0) ? 1 : div;
         m_pend[ch]   = 1'b1;
      end
   endtask

   // Called just after a rising edge; drives inputs, checks ready, then checks the next edge.
   task automatic cycle(input logic [NCH-1:0] e, input bit v, input int ch, input int div, input bit s);
      bit hs;
      en        = e;
      cfg_valid = v;
      cfg_ch    = CHW'(ch);
      cfg_div   = DIVW'(div);
`ifdef CLK_DIV_SYNC_EN
      sync_start = s;
`endif
      #1;
      chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready(ch)));
      hs = v && exp_ready(ch);
      @(posedge clk);
      #1;
      model_step(e, hs, ch, div, s);
      chk("clk_div", 32'(clk_div), 32'(vec_lvl()));
      chk("tick", 32'(tick), 32'(vec_tick()));
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_clk_div", 32'(clk_div), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [NCH-1:0] e_r;
      bit             s_r;
      int             ch_r;
      int             div_r;

      rst       = 1'b1;
      en        = '1;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
`ifdef CLK_DIV_SYNC_EN
      sync_start = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_clk_div", 32'(clk_div), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      #2;
      rst = 1'b0;
      model_reset();

      // Directed: ch1 div=2 at edge 2, ch2 div=0 at edge 3, ch3 held over edges 8..20.
      for (int c = 1; c <= 30; c++) begin
         e_r = '1;
         if (c >= 8 && c <= 20) e_r[3] = 1'b0;
         cycle(e_r, (c == 2 || c == 3), (c == 3) ? 2 : 1, (c == 2) ? 2 : 0, 1'b0);
         case (c)
            2:  chk("lit_ready_ch1_t2", 32'(cfg_ready), 32'd0);
            4:  begin
                   chk("lit_ready_ch1_t4", 32'(cfg_ready), 32'd0);
                   chk("lit_clk0_t4", 32'(clk_div[0]), 32'd0);
                end
            5:  begin
                   chk("lit_ready_ch1_t5", 32'(cfg_ready), 32'd1);
                   chk("lit_clk0_t5", 32'(clk_div[0]), 32'd1);
                   chk("lit_tick0_t5", 32'(tick[0]), 32'd1);
                   chk("lit_clk1_t5", 32'(clk_div[1]), 32'd1);
                end
            6:  chk("lit_tick0_t6", 32'(tick[0]), 32'd0);
            7:  begin
                   chk("lit_clk1_t7", 32'(clk_div[1]), 32'd0);
                   chk("lit_clk2_t7", 32'(clk_div[2]), 32'd1);
                   chk("lit_tick2_t7", 32'(tick[2]), 32'd1);
                end
            8:  begin
                   chk("lit_clk2_t8", 32'(clk_div[2]), 32'd0);
                   chk("lit_tick2_t8", 32'(tick[2]), 32'd0);
                   chk("lit_clk3_t8", 32'(clk_div[3]), 32'd0);
                end
            9:  begin
                   chk("lit_clk1_t9", 32'(clk_div[1]), 32'd1);
                   chk("lit_tick1_t9", 32'(tick[1]), 32'd1);
                   chk("lit_tick2_t9", 32'(tick[2]), 32'd1);
                end
            10: chk("lit_clk0_t10", 32'(clk_div[0]), 32'd0);
            15: chk("lit_tick0_t15", 32'(tick[0]), 32'd1);
            20: chk("lit_clk0_t20", 32'(clk_div[0]), 32'd0);
            24: chk("lit_clk3_t24", 32'(clk_div[3]), 32'd0);
            25: begin
                   chk("lit_clk3_t25", 32'(clk_div[3]), 32'd1);
                   chk("lit_tick3_t25", 32'(tick[3]), 32'd1);
                end
            default: ;
         endcase
      end

      // Reset with a write to ch0 still pending: the write must be lost.
      cycle('1, 1'b1, 0, 3, 1'b0);
      cycle('1, 1'b0, 0, 0, 1'b0);
      chk("lit_ready_ch0_pending", 32'(cfg_ready), 32'd0);
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         cycle('1, 1'b0, 0, 0, 1'b0);
         case (c)
            1:  chk("lit_ready_ch0_after_rst", 32'(cfg_ready), 32'd1);
            4:  chk("lit_rst_clk0_t4", 32'(clk_div[0]), 32'd0);
            5:  chk("lit_rst_clk0_t5", 32'(clk_div[0]), 32'd1);
            8:  chk("lit_rst_clk0_t8", 32'(clk_div[0]), 32'd1);
            10: chk("lit_rst_clk0_t10", 32'(clk_div[0]), 32'd0);
            default: ;
         endcase
      end

      // Write to a channel number beyond CHANNELS: accepted and discarded.
      cycle('1, 1'b1, 6, 1, 1'b0);
      for (int k = 0; k < NCH; k++) begin
         cfg_valid = 1'b0;
         cfg_ch    = CHW'(k);
         #1;
         chk("lit_ready_after_invalid", 32'(cfg_ready), 32'd1);
      end

      // Randomized traffic.
      e_r = '1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 19) == 0) e_r[$urandom_range(0, NCH-1)] ^= 1'b1;
         ch_r  = int'($urandom_range(0, 7));
         div_r = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 6));
`ifdef CLK_DIV_SYNC_EN
         s_r = ($urandom_range(0, 39) == 0);
`else
         s_r = 1'b0;
`endif
         cycle(e_r, ($urandom_range(0, 2) == 0), ch_r, div_r, s_r);
         if ($urandom_range(0, 599) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
